// File: rtl/tx_packet.sv
// UART transmitter for 8-byte read-response frames: STX, 0x00, four payload bytes LSB-first,
// XOR checksum, ETX. A one-entry pending buffer holds a request that arrives while a frame is in flight.
module tx_packet #(
    parameter int BIT_CYCLES = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [31:0] ram_data_out,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [TW-1:0] BIT_LAST = TW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        NEXT
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_q, byte_d;
    logic [31:0]   cur_data_q, cur_data_d;
    logic [7:0]    cur_sum_q, cur_sum_d;
    logic [31:0]   pend_data_q, pend_data_d;
    logic [7:0]    pend_sum_q, pend_sum_d;
    logic          pend_valid_q, pend_valid_d;
    logic          overrun_q, overrun_d;
    logic          tx_q, tx_d;
    logic          bit_end;
    logic          pkt_end;
    logic [7:0]    in_sum;
    logic [7:0]    tx_byte;

    function automatic logic [7:0] xor_bytes(input logic [31:0] d);
        return d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
    endfunction

    assign in_sum  = xor_bytes(ram_data_out);
    assign bit_end = (timer_q == BIT_LAST);
    assign pkt_end = (state_q == STOP) && (byte_q == 3'd7) && bit_end;

    assign busy    = (state_q != IDLE);
    assign done    = pkt_end;
    assign tx      = tx_q;
    assign overrun = overrun_q;

    // The NEXT decision is folded into STOP's last cycle so bytes and frames abut with no gap.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_d        = bit_q;
        byte_d       = byte_q;
        cur_data_d   = cur_data_q;
        cur_sum_d    = cur_sum_q;
        pend_data_d  = pend_data_q;
        pend_sum_d   = pend_sum_q;
        pend_valid_d = pend_valid_q;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d    = START;
                    timer_d    = '0;
                    bit_d      = '0;
                    byte_d     = '0;
                    cur_data_d = ram_data_out;
                    cur_sum_d  = in_sum;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    timer_d = '0;
                    bit_d   = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (byte_q != 3'd7) begin
                        byte_d  = byte_q + 3'd1;
                        state_d = START;
                    end else begin
                        byte_d = '0;
                        if (pend_valid_q) begin
                            state_d      = START;
                            cur_data_d   = pend_data_q;
                            cur_sum_d    = pend_sum_q;
                            pend_valid_d = 1'b0;
                        end else if (tx_start) begin
                            state_d    = START;
                            cur_data_d = ram_data_out;
                            cur_sum_d  = in_sum;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            NEXT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A request during a frame is parked unless the slot is already taken; at frame end an
        // empty slot lets the request launch directly instead.
        if (busy && tx_start) begin
            if (pend_valid_q) begin
                overrun_d = 1'b1;
            end else if (!pkt_end) begin
                pend_data_d  = ram_data_out;
                pend_sum_d   = in_sum;
                pend_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        case (byte_d)
            3'd0:    tx_byte = 8'h02;
            3'd1:    tx_byte = 8'h00;
            3'd2:    tx_byte = cur_data_d[7:0];
            3'd3:    tx_byte = cur_data_d[15:8];
            3'd4:    tx_byte = cur_data_d[23:16];
            3'd5:    tx_byte = cur_data_d[31:24];
            3'd6:    tx_byte = cur_sum_d;
            default: tx_byte = 8'h03;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = tx_byte[bit_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            bit_q        <= '0;
            byte_q       <= '0;
            cur_data_q   <= '0;
            cur_sum_q    <= '0;
            pend_data_q  <= '0;
            pend_sum_q   <= '0;
            pend_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_q        <= bit_d;
            byte_q       <= byte_d;
            cur_data_q   <= cur_data_d;
            cur_sum_q    <= cur_sum_d;
            pend_data_q  <= pend_data_d;
            pend_sum_q   <= pend_sum_d;
            pend_valid_q <= pend_valid_d;
            overrun_q    <= overrun_d;
            tx_q         <= tx_d;
        end
    end

endmodule

// File: tb/tb_tx_packet.sv
// Scoreboard bench for tx_packet: a frame-level model schedules expected frames and done pulses,
// while independent monitors decode the UART line and watch busy/done/overrun.
module tb_tx_packet;

    localparam int BC     = 46;
    localparam int BYTE_T = 10 * BC;
    localparam int PKT    = 80 * BC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_start = 1'b0;
    logic [31:0] ram_data_out = '0;
    logic        tx;
    logic        busy;
    logic        done;
    logic        overrun;

    tx_packet #(.BIT_CYCLES(BC)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_start     (tx_start),
        .ram_data_out (ram_data_out),
        .tx           (tx),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          start;
        logic [31:0] data;
    } pkt_t;

    typedef struct {
        int s;
        int e;
    } span_t;

    int    checks = 0;
    int    errors = 0;
    int    edge_cnt = 0;
    int    done_pulses = 0;
    bit    mon_en = 1'b0;
    pkt_t  exp_pkts[$];
    int    exp_done[$];
    span_t spans[$];
    int    m_last_start = -1000000;
    int    m_last_end = -1000000;
    bit    m_overrun = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got event expected none (edge %0d)", name, edge_cnt);
    endtask

    // Frame bytes straight from the frame format, independent of how the DUT sequences them.
    function automatic logic [7:0] expByte(input logic [31:0] d, input int idx);
        logic [7:0] b[8];
        b[0] = 8'h02;
        b[1] = 8'h00;
        for (int k = 0; k < 4; k++) b[2+k] = d[8*k +: 8];
        b[6] = b[2] ^ b[3] ^ b[4] ^ b[5];
        b[7] = 8'h03;
        return b[idx];
    endfunction

    // A frame occupies edges [start, start+PKT); a request at or before the end of the last
    // scheduled frame is queued behind it unless a queued frame has not yet started.
    function automatic void modelIssue(input logic [31:0] d, input int c);
        int   start;
        pkt_t p;
        if (c > m_last_end) begin
            start = c;
        end else if (m_last_start >= c) begin
            m_overrun = 1'b1;
            return;
        end else begin
            start = m_last_end;
        end
        m_last_start = start;
        m_last_end   = start + PKT;
        p.start = start;
        p.data  = d;
        exp_pkts.push_back(p);
        exp_done.push_back(m_last_end);
        spans.push_back('{start, m_last_end});
    endfunction

    function automatic void modelReset();
        exp_pkts.delete();
        exp_done.delete();
        spans.delete();
        m_last_start = -1000000;
        m_last_end   = -1000000;
        m_overrun    = 1'b0;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (rst && tx_start) modelIssue(ram_data_out, edge_cnt);
        end
    end

    // Cycle-level checks of busy, overrun, idle line and done timing.
    initial begin
        bit exp_b;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (spans.size() > 0 && spans[0].e <= edge_cnt) void'(spans.pop_front());
                exp_b = (spans.size() > 0) && (spans[0].s <= edge_cnt);
                checkOutput("busy", 32'(busy), 32'(exp_b));
                checkOutput("overrun", 32'(overrun), 32'(m_overrun));
                if (!exp_b) checkOutput("tx_idle", 32'(tx), 32'd1);
                if (done) begin
                    done_pulses++;
                    if (exp_done.size() == 0) failNow("unexpected_done");
                    else checkOutput("done_edge", edge_cnt + 1, exp_done.pop_front());
                end
            end
        end
    end

    // UART decoder: samples every clock of a byte, takes mid-bit values and checks bit stability.
    initial begin
        pkt_t       cur;
        bit         have;
        int         byte_idx;
        int         fall;
        logic [9:0] bits;
        logic       first;
        bit         unstable;
        bit         aborted;
        have     = 1'b0;
        byte_idx = 0;
        forever begin
            @(negedge clk);
            if (mon_en && rst && tx == 1'b0) begin
                fall     = edge_cnt;
                bits     = '0;
                first    = 1'b0;
                unstable = 1'b0;
                aborted  = 1'b0;
                for (int j = 0; j < BYTE_T; j++) begin
                    if (j > 0) @(negedge clk);
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (j % BC == 0) first = tx;
                    else if (tx !== first) unstable = 1'b1;
                    if (j % BC == BC / 2) bits[j/BC] = tx;
                end
                if (aborted) begin
                    byte_idx = 0;
                    have     = 1'b0;
                end else begin
                    if (byte_idx == 0) begin
                        if (exp_pkts.size() == 0) begin
                            failNow("unexpected_packet");
                            have = 1'b0;
                        end else begin
                            cur  = exp_pkts.pop_front();
                            have = 1'b1;
                            checkOutput("pkt_start", fall, cur.start);
                        end
                    end
                    if (have) begin
                        checkOutput("byte_fall", fall, cur.start + byte_idx * BYTE_T);
                        checkOutput("byte_val", 32'(bits[8:1]), 32'(expByte(cur.data, byte_idx)));
                    end
                    checkOutput("framing", 32'({bits[9], bits[0]}), 32'd2);
                    checkOutput("bit_stable", 32'(unstable), 32'd0);
                    byte_idx = (byte_idx + 1) % 8;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] d);
        tx_start     = 1'b1;
        ram_data_out = d;
        @(negedge clk);
        tx_start     = 1'b0;
        ram_data_out = $urandom;
    endtask

    task automatic gotoEdge(input int t);
        int g = 0;
        while (edge_cnt < t - 1 && g < 200000) begin
            @(negedge clk);
            g++;
        end
        checkOutput("goto_edge", edge_cnt, t - 1);
    endtask

    task automatic waitIdle();
        int g = 0;
        while (edge_cnt <= m_last_end + 2 && g < 100000) begin
            @(negedge clk);
            g++;
        end
        checkOutput("drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic applyReset();
        #2;
        rst = 1'b0;
        modelReset();
        mon_en = 1'b1;
        #1;
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        int cnt;
        int d0;
        int low;

        applyReset();

        // Single frame: length of busy and one done pulse.
        d0 = done_pulses;
        applyStimulus(32'hA1B2C3D4);
        cnt = 0;
        while (busy && cnt < 10000) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("busy_len", cnt, PKT);
        waitIdle();
        checkOutput("done_count", done_pulses - d0, 1);

        // Second request parked while the first is in flight.
        s = edge_cnt + 1;
        applyStimulus(32'h11111111);
        gotoEdge(s + 100);
        applyStimulus(32'h22222222);
        waitIdle();
        checkOutput("overrun_b2b", 32'(overrun), 32'd0);

        // Third request in one frame is dropped.
        s = edge_cnt + 1;
        applyStimulus(32'h0BADF00D);
        gotoEdge(s + 300);
        applyStimulus(32'h12345678);
        gotoEdge(s + 600);
        applyStimulus(32'hCAFEBABE);
        waitIdle();
        checkOutput("overrun_set", 32'(overrun), 32'd1);

        // Request in the done cycle chains with no idle gap.
        s = edge_cnt + 1;
        applyStimulus(32'h5A5A00FF);
        gotoEdge(s + PKT);
        applyStimulus(32'h80000001);
        low = 0;
        while (edge_cnt < s + 2 * PKT - 1) begin
            @(negedge clk);
            if (!busy) low++;
        end
        checkOutput("busy_gap", low, 0);
        waitIdle();
        checkOutput("overrun_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of byte 3, then a fresh zero frame.
        s = edge_cnt + 1;
        applyStimulus(32'hDEADBEEF);
        gotoEdge(s + 3 * BYTE_T + 150);
        applyReset();
        applyStimulus(32'h00000000);
        waitIdle();

        // Random requests with random spacing.
        for (int i = 0; i < 8; i++) begin
            gotoEdge(edge_cnt + 1 + int'($urandom_range(1, 2500)));
            applyStimulus($urandom);
        end
        waitIdle();

        checkOutput("leftover_pkts", exp_pkts.size(), 0);
        checkOutput("leftover_done", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_packet.md
TX_PACKET -- requirements
Module: tx_packet

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 2604: clocks per UART bit; 46 is used in simulation.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-low (rst=0 resets).
REQ-004 SHALL have port tx_start, input, 1 bit: one-cycle request to send a read-response packet.
REQ-005 SHALL have port ram_data_out, input, 32 bits: read-response payload, valid in the cycle tx_start=1.
REQ-006 SHALL have port tx, output, 1 bit: UART serial line; 1 = idle/mark.
REQ-007 SHALL have port busy, output, 1 bit: high while a packet is being serialized.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse at the end of each packet.
REQ-009 SHALL have port overrun, output, 1 bit: sticky flag, set when a request is dropped.

Function
REQ-010 SHALL sample ram_data_out on every clock where tx_start=1; tx_start is never acknowledged.
REQ-011 Packet SHALL be 8 bytes, in this order:
  - 0x02
  - 0x00
  - D[7:0], D[15:8], D[23:16], D[31:24]
  - checksum = XOR of the four data bytes
  - 0x03
REQ-012 Each byte SHALL be one start bit (0), 8 data bits LSB first, and one stop bit (1), with no gap between bytes.
REQ-013 Each bit SHALL be held on tx for exactly BIT_CYCLES clocks; a packet lasts exactly 80*BIT_CYCLES clocks.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, STOP, NEXT, driven by a bit-timer, a bit counter (0-7) and a byte counter (0-7).
REQ-015 IDLE: tx=1, busy=0. Accepting tx_start at cycle N SHALL give START with tx=0 and busy=1 from cycle N+1.
REQ-016 Transitions:
  - START -> DATA after BIT_CYCLES.
  - DATA -> STOP after the 8th bit.
  - STOP -> NEXT after BIT_CYCLES.
  - NEXT: byte counter <7 -> START of next byte with no extra cycle (NEXT is zero-time or absorbed into STOP's last cycle).
  - NEXT: byte counter =7 -> packet end.
REQ-017 done SHALL be 1 in exactly the last clock of byte 7's stop bit.
REQ-018 Packet end:
  - Pending buffer empty: busy=0 from the next cycle.
  - Pending buffer full: the next packet's start bit begins on the next cycle, busy stays 1, and the buffer empties.
REQ-019 SHALL have a one-entry pending buffer. tx_start while busy=1:
  - Buffer empty: store the data.
  - Buffer full: drop the request and set overrun=1.
REQ-020 tx_start in the same cycle as done SHALL be treated as busy=1 (REQ-019 applies) and SHALL NOT be lost.
REQ-021 overrun SHALL clear only on reset.
REQ-022 tx SHALL come from a register (glitch-free).
REQ-023 The checksum SHALL be computed at capture time, not during serialization.

Reset
REQ-024 rst=0 SHALL asynchronously force these values:
  - tx=1, busy=0, done=0, overrun=0
  - pending buffer empty, all counters 0, FSM IDLE
REQ-025 Reset in mid-packet SHALL abort it immediately (tx=1 that cycle); no partial resume after release.
REQ-026 The first tx_start SHALL be accepted on the first rising clock edge after rst returns to 1.

Verification (BIT_CYCLES=46)
REQ-027 tx_start with ram_data_out=0xA1B2C3D4 -> the bench SHALL see:
  - Decoded bytes 02 00 D4 C3 B2 A1 04 03.
  - busy high for exactly 3680 clocks.
  - done pulses once.
REQ-028 Bit timing check: tx falls 1 clock after tx_start, and every tx edge falls on a multiple of 46 clocks from that fall.
REQ-029 Back-to-back request: tx_start 0x11111111, then tx_start 0x22222222 at clock 100 -> two packets with no idle gap:
  - Second packet bytes 02 00 22 22 22 22 00 03.
  - overrun=0.
REQ-030 Overflow: three tx_start pulses during one packet -> only the first two packets are sent, and overrun=1 stays set until reset.
REQ-031 tx_start in the done cycle -> a second packet follows with no gap and busy never drops.
REQ-032 rst=0 during byte 3 -> tx=1 and busy=0 at once; tx_start 0x0 after release -> packet 02 00 00 00 00 00 00 03.
